rgb_hue_sequencer: RTL and testbench

RGB_HUE_SEQUENCER -- requirements
Module: rgb_hue_sequencer

---
 rtl/rgb_hue_sequencer.sv | 108 ++++++++++
 tb/tb_rgb_hue_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rgb_hue_sequencer.sv
// RGB hue sequencer: walks the three PWM duty values around the colour wheel
// in six phases (G up, R down, B up, G down, R up, B down). A 32-bit
// prescaler sets how many clock cycles pass between duty steps.
module rgb_hue_sequencer #(
  parameter int R = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         restart,
  input  logic [31:0]  step_div,
  output logic [R:0]   duty_r,
  output logic [R:0]   duty_g,
  output logic [R:0]   duty_b,
  output logic [2:0]   phase,
  output logic         step,
  output logic         cycle_done
);

  // Each phase names the channel it moves and the direction it moves it in.
  typedef enum logic [2:0] {
    PH_G_UP = 3'd0,
    PH_R_DN = 3'd1,
    PH_B_UP = 3'd2,
    PH_G_DN = 3'd3,
    PH_R_UP = 3'd4,
    PH_B_DN = 3'd5
  } phase_t;

  localparam logic [R:0] FULL = {1'b1, {R{1'b0}}};

  phase_t      phase_q;
  phase_t      phase_next;
  logic [31:0] prescaler;
  logic [31:0] div_eff;
  logic        tick;
  logic [R:0]  cur_duty;
  logic        dir_up;
  logic        at_target;
  logic [R:0]  stepped_duty;
  logic        reach_target;

  assign phase = phase_q;

  // A divisor of zero behaves like one. The tick uses >= so that lowering
  // step_div below the running count ticks on the next cycle, no 2**32 wrap.
  always_comb begin
    div_eff = (step_div == 32'd0) ? 32'd1 : step_div;
    tick    = en && (prescaler >= (div_eff - 32'd1));
  end

  // Select the channel moved by the current phase and work out its next value.
  always_comb begin
    cur_duty   = '0;
    dir_up     = 1'b0;
    phase_next = PH_G_UP;
    case (phase_q)
      PH_G_UP: begin cur_duty = duty_g; dir_up = 1'b1; phase_next = PH_R_DN; end
      PH_R_DN: begin cur_duty = duty_r; dir_up = 1'b0; phase_next = PH_B_UP; end
      PH_B_UP: begin cur_duty = duty_b; dir_up = 1'b1; phase_next = PH_G_DN; end
      PH_G_DN: begin cur_duty = duty_g; dir_up = 1'b0; phase_next = PH_R_UP; end
      PH_R_UP: begin cur_duty = duty_r; dir_up = 1'b1; phase_next = PH_B_DN; end
      PH_B_DN: begin cur_duty = duty_b; dir_up = 1'b0; phase_next = PH_G_UP; end
      default: begin cur_duty = '0;     dir_up = 1'b0; phase_next = PH_G_UP; end
    endcase
    at_target    = dir_up ? (cur_duty >= FULL) : (cur_duty == '0);
    stepped_duty = dir_up ? (cur_duty + 1'b1) : (cur_duty - 1'b1);
    reach_target = at_target || (stepped_duty == (dir_up ? FULL : '0));
  end

  // Prescaler, phase and duty registers; step and cycle_done are one-cycle
  // registered pulses following the tick edge that caused them.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      prescaler  <= 32'd0;
      phase_q    <= PH_G_UP;
      duty_r     <= FULL;
      duty_g     <= '0;
      duty_b     <= '0;
      step       <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      step       <= 1'b0;
      cycle_done <= 1'b0;
      if (en) begin
        if (tick) begin
          prescaler <= 32'd0;
          step      <= 1'b1;
          if (!at_target) begin
            case (phase_q)
              PH_G_UP, PH_G_DN: duty_g <= stepped_duty;
              PH_R_DN, PH_R_UP: duty_r <= stepped_duty;
              PH_B_UP, PH_B_DN: duty_b <= stepped_duty;
              default: ;
            endcase
          end
          if (reach_target) begin
            phase_q <= phase_next;
            if (phase_q == PH_B_DN) cycle_done <= 1'b1;
          end
        end else begin
          prescaler <= prescaler + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rgb_hue_sequencer.sv
// Directed testbench for rgb_hue_sequencer with R = 8 and hand-computed
// expectations for every check.
module tb_rgb_hue_sequencer;

  localparam int R = 8;

  logic         clk;
  logic         rst;
  logic         en;
  logic         restart;
  logic [31:0]  step_div;
  logic [R:0]   duty_r;
  logic [R:0]   duty_g;
  logic [R:0]   duty_b;
  logic [2:0]   phase;
  logic         step;
  logic         cycle_done;

  int testCount;
  int failCount;
  int stepCount;
  int doneCount;
  logic [7:0] phaseMask;

  rgb_hue_sequencer #(.R(R)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .restart    (restart),
    .step_div   (step_div),
    .duty_r     (duty_r),
    .duty_g     (duty_g),
    .duty_b     (duty_b),
    .phase      (phase),
    .step       (step),
    .cycle_done (cycle_done)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value and tally the result.
  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Advance a number of clock edges, sampling 1 ns after each edge and
  // tallying step pulses, cycle_done pulses and phases visited.
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (step) stepCount++;
      if (cycle_done) doneCount++;
      phaseMask[phase] = 1'b1;
    end
  endtask

  task automatic clearCounts();
    stepCount = 0;
    doneCount = 0;
    phaseMask = '0;
  endtask

  task automatic checkRgb(input string tag, input int r, input int g, input int b, input int ph);
    checkOutput({tag, "_r"}, duty_r, r);
    checkOutput({tag, "_g"}, duty_g, g);
    checkOutput({tag, "_b"}, duty_b, b);
    checkOutput({tag, "_phase"}, phase, ph);
  endtask

  task automatic pulseRestart();
    restart = 1'b1;
    applyStimulus(1);
    restart = 1'b0;
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    clearCounts();
    rst      = 1'b1;
    en       = 1'b1;
    restart  = 1'b0;
    step_div = 32'd1;
    applyStimulus(2);

    // Reset state
    checkRgb("reset", 256, 0, 0, 0);
    checkOutput("reset_step", step, 0);
    checkOutput("reset_done", cycle_done, 0);

    // Case 1: step_div=1, 256 ticks finish phase 0
    rst = 1'b0;
    clearCounts();
    applyStimulus(255);
    checkRgb("c1_255", 256, 255, 0, 0);
    applyStimulus(1);
    checkRgb("c1_256", 256, 256, 0, 1);
    checkOutput("c1_step", step, 1);
    checkOutput("c1_stepcount", stepCount, 256);

    // Case 2: full cycle of 1536 ticks
    applyStimulus(1279);
    checkRgb("c2_1535", 256, 0, 1, 5);
    checkOutput("c2_done_early", doneCount, 0);
    applyStimulus(1);
    checkRgb("c2_1536", 256, 0, 0, 0);
    checkOutput("c2_done_now", cycle_done, 1);
    checkOutput("c2_done_count", doneCount, 1);
    checkOutput("c2_phases", phaseMask, 8'h3F);
    applyStimulus(1);
    checkOutput("c2_done_clear", cycle_done, 0);
    checkRgb("c2_next", 256, 1, 0, 0);

    // Case 3: step_div=4 gives a step every 4th cycle
    pulseRestart();
    checkRgb("c3_restart", 256, 0, 0, 0);
    checkOutput("c3_restart_step", step, 0);
    step_div = 32'd4;
    clearCounts();
    applyStimulus(3);
    checkOutput("c3_nostep", stepCount, 0);
    applyStimulus(1);
    checkOutput("c3_first_step", step, 1);
    checkOutput("c3_g1", duty_g, 1);
    clearCounts();
    applyStimulus(12);
    checkOutput("c3_stepcount", stepCount, 3);
    checkOutput("c3_g4", duty_g, 4);

    // Case 3b: step_div=0 behaves like step_div=1
    pulseRestart();
    step_div = 32'd0;
    clearCounts();
    applyStimulus(256);
    checkRgb("c3z_256", 256, 256, 0, 1);
    checkOutput("c3z_stepcount", stepCount, 256);

    // Case 4: en low in phase 2 at duty_b=37
    pulseRestart();
    step_div = 32'd1;
    applyStimulus(549);
    checkRgb("c4_pre", 0, 256, 37, 2);
    en = 1'b0;
    clearCounts();
    applyStimulus(100);
    checkRgb("c4_hold", 0, 256, 37, 2);
    checkOutput("c4_nostep", stepCount, 0);
    checkOutput("c4_step_low", step, 0);
    en = 1'b1;
    applyStimulus(1);
    checkOutput("c4_b38", duty_b, 38);
    checkOutput("c4_step", step, 1);

    // Case 5: restart, then rst, in phase 3 at duty_g=120
    pulseRestart();
    applyStimulus(904);
    checkRgb("c5_pre", 0, 120, 256, 3);
    clearCounts();
    pulseRestart();
    checkRgb("c5_restart", 256, 0, 0, 0);
    checkOutput("c5_restart_done", doneCount, 0);
    checkOutput("c5_restart_step", step, 0);
    applyStimulus(904);
    checkRgb("c5_pre2", 0, 120, 256, 3);
    clearCounts();
    rst = 1'b1;
    applyStimulus(1);
    checkRgb("c5_rst", 256, 0, 0, 0);
    checkOutput("c5_rst_done", doneCount, 0);
    checkOutput("c5_rst_step", step, 0);

    // Case 6: step_div drops from 1000 to 10 at prescaler=500
    step_div = 32'd1000;
    applyStimulus(1);
    rst = 1'b0;
    clearCounts();
    applyStimulus(500);
    checkOutput("c6_nostep", stepCount, 0);
    step_div = 32'd10;
    applyStimulus(1);
    checkOutput("c6_immediate", step, 1);
    checkOutput("c6_g1", duty_g, 1);
    clearCounts();
    applyStimulus(9);
    checkOutput("c6_gap", stepCount, 0);
    applyStimulus(1);
    checkOutput("c6_tenth", step, 1);
    checkOutput("c6_g2", duty_g, 2);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
